// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame sizes and a
// microsecond-to-cycle helper used by both the host transmitter and receiver.
package ps2_pkg;

  localparam int unsigned FRAME_DATA_BITS  = 8;
  localparam int unsigned FRAME_TOTAL_BITS = 11;

  typedef enum logic [3:0] {
    StIdle,
    StInhibit,
    StReq,
    StData,
    StParity,
    StStop,
    StAck,
    StDone,
    StFail
  } ps2_tx_state_e;

  function automatic int unsigned us_to_cycles(input int unsigned freq_hz,
                                               input int unsigned us);
    return (freq_hz / 32'd1_000_000) * us;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for an open-collector PS/2 line plus falling-edge
// detect; idles high so reset never produces a spurious edge.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic sync,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync = sync_q;
  assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter with timeout supervision and retry.
// Define PS2_TX_ACK_CHECK_EN to treat a device nack as a failed attempt.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned INHIBIT_US  = 200,
  parameter int unsigned TIMEOUT_US  = 2000,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_MOUSE_IN,
  output logic       CLK_MOUSE_OUT_EN,
  input  logic       DATA_MOUSE_IN,
  output logic       DATA_MOUSE_OUT,
  output logic       DATA_MOUSE_OUT_EN,
  input  logic       SEND_BYTE,
  input  logic [7:0] BYTE_TO_SEND,
  output logic       BUSY,
  output logic       BYTE_SENT,
  output logic       BYTE_ERROR
);

  localparam int unsigned INH_CYC = us_to_cycles(CLK_FREQ_HZ, INHIBIT_US);
  localparam int unsigned TO_CYC  = us_to_cycles(CLK_FREQ_HZ, TIMEOUT_US);
  localparam int unsigned MAX_CYC = (INH_CYC > TO_CYC) ? INH_CYC : TO_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CNT_W-1:0]   INH_LAST  = CNT_W'(INH_CYC - 1);
  localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(TO_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [2:0]         LAST_BIT  = 3'(FRAME_DATA_BITS - 1);

  ps2_tx_state_e      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [7:0]         byte_q, byte_d;
  logic               parity_q, parity_d;
  logic [2:0]         bit_idx_q, bit_idx_d;

  logic clk_sync, clk_fall;
  logic data_sync, data_fall;
  logic accept, retry;

  ps2_line_sync u_clk_sync (
    .clk  (CLK),
    .rst_n(RESET),
    .line (CLK_MOUSE_IN),
    .sync (clk_sync),
    .fall (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk  (CLK),
    .rst_n(RESET),
    .line (DATA_MOUSE_IN),
    .sync (data_sync),
    .fall (data_fall)
  );

`ifdef PS2_TX_ACK_CHECK_EN
  logic nack_q, nack_d;
  logic unused_sync;
  assign unused_sync = ^{clk_sync, data_fall};

  always_ff @(posedge CLK) begin
    if (!RESET) nack_q <= 1'b0;
    else        nack_q <= nack_d;
  end
`else
  logic unused_sync;
  assign unused_sync = ^{clk_sync, data_fall, data_sync};
`endif

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      retry_q   <= '0;
      byte_q    <= '0;
      parity_q  <= 1'b0;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      byte_q    <= byte_d;
      parity_q  <= parity_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    byte_d    = byte_q;
    parity_d  = parity_q;
    bit_idx_d = bit_idx_q;
`ifdef PS2_TX_ACK_CHECK_EN
    nack_d    = nack_q;
`endif
    accept    = 1'b0;
    retry     = 1'b0;

    CLK_MOUSE_OUT_EN  = 1'b0;
    DATA_MOUSE_OUT_EN = 1'b0;
    DATA_MOUSE_OUT    = 1'b1;
    BUSY              = 1'b1;
    BYTE_SENT         = 1'b0;
    BYTE_ERROR        = 1'b0;

    unique case (state_q)
      StIdle: begin
        BUSY   = 1'b0;
        accept = SEND_BYTE;
      end
      StInhibit: begin
        CLK_MOUSE_OUT_EN = 1'b1;
        if (cnt_q == INH_LAST) begin
          cnt_d   = '0;
          state_d = StReq;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StReq: begin
        DATA_MOUSE_OUT_EN = 1'b1;
        DATA_MOUSE_OUT    = 1'b0;
        if (clk_fall) begin
          bit_idx_d = '0;
          state_d   = StData;
        end
      end
      StData: begin
        DATA_MOUSE_OUT_EN = 1'b1;
        DATA_MOUSE_OUT    = byte_q[bit_idx_q];
        if (clk_fall) begin
          if (bit_idx_q == LAST_BIT) state_d = StParity;
          else                       bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      StParity: begin
        DATA_MOUSE_OUT_EN = 1'b1;
        DATA_MOUSE_OUT    = parity_q;
        if (clk_fall) state_d = StStop;
      end
      StStop: begin
        // Data released: the device reads the stop bit, then pulls low to ack
        if (clk_fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
          nack_d = data_sync;
`endif
          state_d = StAck;
        end
      end
      StAck: begin
`ifdef PS2_TX_ACK_CHECK_EN
        if (nack_q) retry = 1'b1;
        else        state_d = StDone;
`else
        state_d = StDone;
`endif
      end
      StDone: begin
        BUSY      = 1'b0;
        BYTE_SENT = 1'b1;
        state_d   = StIdle;
        accept    = SEND_BYTE;
      end
      StFail: begin
        BUSY       = 1'b0;
        BYTE_ERROR = 1'b1;
        state_d    = StIdle;
        accept     = SEND_BYTE;
      end
      default: state_d = StIdle;
    endcase

    // Gap supervision between device clock edges; a coincident edge wins
    if (state_q inside {StReq, StData, StParity, StStop}) begin
      if (clk_fall)              cnt_d = '0;
      else if (cnt_q == TO_LAST) retry = 1'b1;
      else                       cnt_d = cnt_q + 1'b1;
    end

    if (retry) begin
      cnt_d     = '0;
      bit_idx_d = '0;
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + 1'b1;
        state_d = StInhibit;
      end else begin
        state_d = StFail;
      end
    end

    if (accept) begin
      byte_d    = BYTE_TO_SEND;
      parity_d  = ~^BYTE_TO_SEND;
      retry_d   = '0;
      cnt_d     = '0;
      bit_idx_d = '0;
      state_d   = StInhibit;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with an open-collector PS/2 device model.
module tb_ps2_host_tx;

  // 2 MHz clock: 20 us inhibit = 40 cycles, 100 us timeout = 200 cycles
  localparam int unsigned INH_CYC = 40;
  localparam int HALF = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clk_out_en, data_out, data_out_en;
  logic       send_byte;
  logic [7:0] byte_in;
  logic       busy, sent, err;
  logic       dev_clk, dev_data;
  logic       clk_line, data_line;

  always #5 clk = ~clk;

  assign clk_line  = ~clk_out_en & dev_clk;
  assign data_line = (data_out_en ? data_out : 1'b1) & dev_data;

  ps2_host_tx #(
    .CLK_FREQ_HZ(2_000_000),
    .INHIBIT_US (20),
    .TIMEOUT_US (100),
    .MAX_RETRY  (2)
  ) dut (
    .CLK              (clk),
    .RESET            (rst_n),
    .CLK_MOUSE_IN     (clk_line),
    .CLK_MOUSE_OUT_EN (clk_out_en),
    .DATA_MOUSE_IN    (data_line),
    .DATA_MOUSE_OUT   (data_out),
    .DATA_MOUSE_OUT_EN(data_out_en),
    .SEND_BYTE        (send_byte),
    .BYTE_TO_SEND     (byte_in),
    .BUSY             (busy),
    .BYTE_SENT        (sent),
    .BYTE_ERROR       (err)
  );

  int tests = 0;
  int fails = 0;
  int sent_cnt = 0, err_cnt = 0, inh_cnt = 0;
  int s0, e0, i0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Frame as the device sees it: start, D0..D7, odd parity, stop
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = (($countones(b) % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Per-cycle compare against the handshake/line rules
  logic exp_busy = 1'b0, prev_busy = 1'b0, prev_pulse = 1'b0, prev_en = 1'b0;
  int run = 0;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      exp_busy = 1'b0;
      check("reset_outputs", {26'd0, clk_out_en, data_out_en, data_out, busy, sent, err},
            32'b001000);
    end else begin
      if (send_byte && !prev_busy) exp_busy = 1'b1;
      check("busy", busy, exp_busy && !(sent | err));
      if (!busy) check("idle_lines", {clk_out_en, data_out_en, data_out}, 3'b001);
      else       check("enable_excl", clk_out_en & data_out_en, 0);
      if (sent | err) begin
        check("pulse_width", prev_pulse, 0);
        exp_busy = 1'b0;
      end
      if (sent) sent_cnt++;
      if (err)  err_cnt++;
    end
    if (clk_out_en) run++;
    else if (prev_en) begin
      check("inhibit_len", run, INH_CYC);
      run = 0;
    end
    if (clk_out_en && !prev_en) inh_cnt++;
    prev_en    = clk_out_en;
    prev_busy  = busy;
    prev_pulse = sent | err;
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    send_byte = 1'b1;
    byte_in   = b;
    @(negedge clk);
    send_byte = 1'b0;
  endtask

  task automatic snap();
    s0 = sent_cnt;
    e0 = err_cnt;
    i0 = inh_cnt;
  endtask

  task automatic expect_counts(input string tag, input int ds, input int de, input int di);
    check({tag, "_sent"}, sent_cnt - s0, ds);
    check({tag, "_err"}, err_cnt - e0, de);
    check({tag, "_inhibits"}, inh_cnt - i0, di);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", busy, 0);
  endtask

  // Device: waits out the inhibit, then clocks nclk pulses, reading on rising edges
  task automatic dev_frame(input bit ack, input int nclk, output logic [10:0] frame);
    int n = 0;
    frame = '0;
    while (!clk_out_en && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("inhibit_seen", clk_out_en, 1);
    n = 0;
    while (clk_out_en && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    frame[0] = data_line;
    for (int k = 1; k <= nclk; k++) begin
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (k <= 10) frame[k] = data_line;
      if (k == 10 && ack) dev_data = 1'b0;
    end
    dev_data = 1'b1;
  endtask

  logic [10:0] fr;
  logic [7:0]  vec [3] = '{8'h00, 8'h81, 8'h6D};

  initial begin
    rst_n     = 1'b0;
    send_byte = 1'b0;
    byte_in   = 8'h00;
    dev_clk   = 1'b1;
    dev_data  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_clk_en", clk_out_en, 0);
    check("rst_data_en", data_out_en, 0);
    check("rst_data_out", data_out, 1);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 0xF4 acked: D0..D7 = 0,0,1,0,1,1,1,1, parity 0, stop 1
    snap();
    send(8'hF4);
    check("f4_busy_rise", busy, 1);
    dev_frame(1'b1, 11, fr);
    check("f4_frame", fr, 11'b10_1111_0100_0);
    wait_idle();
    expect_counts("f4", 1, 0, 1);

    // 0xFF: even count of ones, parity bit 1
    snap();
    send(8'hFF);
    dev_frame(1'b1, 11, fr);
    check("ff_frame", fr, 11'b11_1111_1111_0);
    wait_idle();
    expect_counts("ff", 1, 0, 1);

    // Nack on first attempt
    snap();
    send(8'h3C);
    dev_frame(1'b0, 11, fr);
    check("nack_frame1", fr, model_frame(8'h3C));
`ifdef PS2_TX_ACK_CHECK_EN
    dev_frame(1'b1, 11, fr);
    check("nack_frame2", fr, model_frame(8'h3C));
    wait_idle();
    expect_counts("nack_retry", 1, 0, 2);
`else
    wait_idle();
    expect_counts("nack_ignored", 1, 0, 1);
`endif

    // Device stops clocking after D3 on every attempt
    snap();
    send(8'hE8);
    for (int a = 0; a < 3; a++) dev_frame(1'b1, 4, fr);
    wait_idle();
    expect_counts("stall", 0, 1, 3);
    check("stall_lines", {clk_out_en, data_out_en}, 2'b00);

    // Reset during DATA releases the lines with no pulse
    snap();
    send(8'h5A);
    while (clk_out_en) @(negedge clk);
    repeat (4) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
    end
    check("pre_reset_data_en", data_out_en, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_lines", {clk_out_en, data_out_en, data_out}, 3'b001);
    check("midrst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    expect_counts("midrst", 0, 0, 1);

    // Second request while busy is dropped
    snap();
    send(8'hA5);
    send(8'h3C);
    dev_frame(1'b1, 11, fr);
    check("busy_ignore_frame", fr, model_frame(8'hA5));
    wait_idle();
    expect_counts("busy_ignore", 1, 0, 1);

    foreach (vec[j]) begin
      snap();
      send(vec[j]);
      dev_frame(1'b1, 11, fr);
      check("vec_frame", fr, model_frame(vec[j]));
      wait_idle();
      expect_counts("vec", 1, 0, 1);
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
